wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writer side of the 32-entry register file's single write port.
- Merges two result sources onto write_addr/write_data/write_en:
  - the primary pipeline result (port A), which never waits;
  - a long-latency unit such as mul/div or a multi-cycle load (port B), which hands results over with valid/ready and is buffered in a small FIFO.
- Keeps a busy scoreboard of registers with an outstanding port-B result, so decode can stall on RAW hazards.

Parameters:
- DEPTH, 4, port-B FIFO entries; power of 2, at least 2.
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO head may lose arbitration before port A is stalled.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_valid  in  1  primary result valid this cycle.
- a_addr  in  5  primary destination register.
- a_data  in  32  primary result.
- a_stall  out  1  port A must not present a result next cycle.
- b_valid  in  1  long-latency result offered.
- b_ready  out  1  FIFO can accept; a transfer occurs when b_valid and b_ready are both high.
- b_addr  in  5  long-latency destination register.
- b_data  in  32  long-latency result.
- rsv_en  in  1  issue has reserved a destination for a long-latency op.
- rsv_addr  in  5  register being reserved.
- write_en  out  1  regfile write enable.
- write_addr  out  5  regfile write address.
- write_data  out  32  regfile write data.
- busy  out  32  bit r is 1 while register r has a pending port-B result; bit 0 is always 0.

Behaviour:
- Reset (rst high, asynchronous):
  - write_en=0, write_addr=0, write_data=0.
  - FIFO empty, so b_ready=1.
  - busy=0, starve counter=0, a_stall=0.
- Write port outputs are registered. Each cycle exactly one winner is selected and loaded into the output registers; write_en is high for one cycle only.
- Port A request is a_valid && a_addr!=0. An A result at cycle t appears as write_en during t+1. A results with a_addr=0 are dropped and do not count as winning.
- FIFO:
  - Push on b_valid && b_ready.
  - b_ready = count<DEPTH, driven from registered count only; there is no same-cycle push-on-pop when full.
  - A pushed entry is visible at the head from the next cycle.
  - Entries with b_addr=0 are pushed normally and popped without asserting write_en.
- Arbitration order each cycle:
  - A request wins if present and a_stall was low. The FIFO head waits and the starve counter increments.
  - Otherwise, if the FIFO is non-empty, the head pops and is written; the starve counter clears.
  - Otherwise nothing is written: write_en=0 and the address/data registers hold.
- Best-case B latency: handshake at t, head at t+1, write_en during t+2.
- Starvation:
  - When the starve counter reaches STARVE_MAX-1 with the head still waiting, a_stall is asserted (registered) for exactly one cycle.
  - During that cycle the head wins unconditionally.
  - Port A presenting a_valid while a_stall is high is a protocol error (assertion); that result is discarded.
- Scoreboard:
  - rsv_en with rsv_addr!=0 sets busy[rsv_addr] at the clock edge.
  - Popping a head entry with addr r clears busy[r] on the same edge in which write_en for it is loaded.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - rsv_addr=0 is ignored.
- Hazard contract:
  - Issue logic never sends an A result to a busy register (assertion: a_valid && busy[a_addr] is an error).
  - Issue logic never reserves an already-busy register.
  - B results return in reservation order.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset mid-operation discards all FIFO contents and busy bits immediately. No partial write is issued.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32;
  - a wb_req struct {valid, addr[4:0], data[31:0]} used for both port A and port B.
- One sub-module: wb_fifo, a parameterised DEPTH x 37-bit synchronous FIFO.
  - Interfaces: push/pop, full/empty, count.
  - Reset: asynchronous, active-high.
- Arbitration, starve counter and scoreboard stay in wb_arbiter.

Test Plan:
- Reset, then a_valid=1, a_addr=5, a_data=0xDEADBEEF at t -> write_en=1, write_addr=5, write_data=0xDEADBEEF at t+1; write_en=0 at t+2.
- rsv_en, rsv_addr=7 at t -> busy[7]=1 at t+1; B push addr=7, data=0x12 with A idle -> write_en with addr 7, data 0x12 two cycles after the push, and busy[7]=0 in that same cycle.
- Hold A valid every cycle with distinct addresses and push four B entries -> b_ready=0 after the 4th push, and a_stall pulses after STARVE_MAX=8 losing cycles. Each stall drains one B entry, in FIFO order.
- a_addr=0 with a_valid=1 plus a pending B head -> B head written in that slot; B entry with addr 0 -> popped with write_en=0 and count decremented.
- Same-cycle rsv_en for register 9 and pop of a B entry for register 9 -> busy[9] remains 1.
- Assert rst asynchronously mid-burst with a full FIFO and busy=0x0000_0F00 -> all outputs zero and b_ready=1 immediately, without waiting for a clock edge; no further writes after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the write-request record used by both result sources of the
// register-file writer.
package wb_arbiter_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned NUM_REGS   = 32;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // FIFO entries carry address and data only; validity is implied by occupancy.
   function automatic logic [REG_ADDR_W+XLEN-1:0] pack_entry(input wb_req_t req);
      return {req.addr, req.data};
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with occupancy count; storage is not reset,
// only the pointers and count.
module wb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 37
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [PtrW:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == FullCnt);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PtrW'(1);
         if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (PtrW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (PtrW+1)'(1);
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: primary results win, long-latency results are
// buffered and forced through after STARVE_MAX losses; tracks pending destinations.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   input  logic [REG_ADDR_W-1:0] a_addr,
   input  logic [XLEN-1:0]       a_data,
   output logic                  a_stall,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [REG_ADDR_W-1:0] b_addr,
   input  logic [XLEN-1:0]       b_data,
   input  logic                  rsv_en,
   input  logic [REG_ADDR_W-1:0] rsv_addr,
   output logic                  write_en,
   output logic [REG_ADDR_W-1:0] write_addr,
   output logic [XLEN-1:0]       write_data,
   output logic [NUM_REGS-1:0]   busy
);

   localparam int unsigned EntryW  = REG_ADDR_W + XLEN;
   localparam int unsigned CntW    = $clog2(DEPTH) + 1;
   localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
   localparam logic [CntW-1:0]    DepthCnt  = DEPTH[CntW-1:0];
   localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX - 1);

   logic                  r_write_en;
   logic [REG_ADDR_W-1:0] r_write_addr;
   logic [XLEN-1:0]       r_write_data;
   logic [NUM_REGS-1:0]   r_busy;
   logic [StarveW-1:0]    r_starve;
   logic                  r_a_stall;

   logic                  w_write_en;
   logic [REG_ADDR_W-1:0] w_write_addr;
   logic [XLEN-1:0]       w_write_data;
   logic [NUM_REGS-1:0]   w_busy;
   logic [StarveW-1:0]    w_starve;
   logic                  w_a_stall;

   wb_req_t           w_a;
   wb_req_t           w_b;
   wb_req_t           w_head;
   logic [EntryW-1:0] w_head_raw;
   logic              w_push;
   logic              w_pop;
   logic              w_win_a;
   logic              w_full;
   logic              w_empty;
   logic [CntW-1:0]   w_count;

   assign w_a     = '{valid: a_valid && (a_addr != '0), addr: a_addr, data: a_data};
   assign w_b     = '{valid: b_valid, addr: b_addr, data: b_data};
   assign w_head  = wb_req_t'({!w_empty, w_head_raw});
   assign b_ready = (w_count < DepthCnt);
   assign w_push  = w_b.valid && b_ready;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EntryW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (pack_entry(w_b)),
      .i_pop   (w_pop),
      .o_rdata (w_head_raw),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_write_en   = 1'b0;
      w_write_addr = r_write_addr;
      w_write_data = r_write_data;
      w_starve     = r_starve;
      w_a_stall    = 1'b0;
      w_win_a      = w_a.valid && !r_a_stall;
      w_pop        = !w_win_a && w_head.valid;

      if (w_win_a) begin
         w_write_en   = 1'b1;
         w_write_addr = w_a.addr;
         w_write_data = w_a.data;
         if (w_head.valid) begin
            w_starve  = r_starve + StarveW'(1);
            w_a_stall = (r_starve == StarveLim);
         end
      end else if (w_pop) begin
         w_starve = '0;
         // Entries for x0 drain silently.
         if (w_head.addr != '0) begin
            w_write_en   = 1'b1;
            w_write_addr = w_head.addr;
            w_write_data = w_head.data;
         end
      end

      // Set is applied after clear so a same-cycle reservation wins.
      w_busy = r_busy;
      if (w_pop)  w_busy[w_head.addr] = 1'b0;
      if (rsv_en) w_busy[rsv_addr]    = 1'b1;
      w_busy[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write_en   <= 1'b0;
         r_write_addr <= '0;
         r_write_data <= '0;
         r_busy       <= '0;
         r_starve     <= '0;
         r_a_stall    <= 1'b0;
      end else begin
         r_write_en   <= w_write_en;
         r_write_addr <= w_write_addr;
         r_write_data <= w_write_data;
         r_busy       <= w_busy;
         r_starve     <= w_starve;
         r_a_stall    <= w_a_stall;
      end
   end

   assign write_en   = r_write_en;
   assign write_addr = r_write_addr;
   assign write_data = r_write_data;
   assign busy       = r_busy;
   assign a_stall    = r_a_stall;

   a_valid_during_stall: assert property (@(posedge clk) disable iff (rst)
      !(a_valid && r_a_stall))
      else $error("wb_arbiter: a_valid presented while a_stall is high");

   a_write_to_busy: assert property (@(posedge clk) disable iff (rst)
      !(a_valid && r_busy[a_addr]))
      else $error("wb_arbiter: port A result targets a busy register");

   push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(w_push && w_full))
      else $error("wb_arbiter: push into a full FIFO");

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one task per scenario, inline comparisons against
// hand-derived values, single summary line at the end.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        a_stall;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_arbiter #(
      .DEPTH      (4),
      .STARVE_MAX (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_addr     (a_addr),
      .a_data     (a_data),
      .a_stall    (a_stall),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_addr     (b_addr),
      .b_data     (b_data),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .write_en   (write_en),
      .write_addr (write_addr),
      .write_data (write_data),
      .busy       (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reserve(input logic [4:0] r);
      rsv_en   = 1'b1;
      rsv_addr = r;
      step();
      rsv_en   = 1'b0;
      rsv_addr = '0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      a_valid  = 1'b0; a_addr = '0; a_data = '0;
      b_valid  = 1'b0; b_addr = '0; b_data = '0;
      rsv_en   = 1'b0; rsv_addr = '0;
      step();
      total++;
      if ({write_en, write_addr, write_data} !== 38'd0) begin
         bad++; $display("FAIL reset_write got=%0b/%0d/%h want=0/0/0", write_en, write_addr, write_data);
      end
      total++;
      if (b_ready !== 1'b1) begin bad++; $display("FAIL reset_b_ready got=%b want=1", b_ready); end
      total++;
      if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy); end
      total++;
      if (a_stall !== 1'b0) begin bad++; $display("FAIL reset_a_stall got=%b want=0", a_stall); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_a_basic();
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
      step();
      a_valid = 1'b0;
      total++;
      if (write_en !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
         bad++; $display("FAIL a_write got=%b/%0d/%h want=1/5/deadbeef", write_en, write_addr, write_data);
      end
      step();
      total++;
      if (write_en !== 1'b0 || write_addr !== 5'd5) begin
         bad++; $display("FAIL a_one_shot got=%b/%0d want=0/5", write_en, write_addr);
      end
   endtask

   task automatic test_b_basic();
      reserve(5'd7);
      total++;
      if (busy !== 32'h0000_0080) begin bad++; $display("FAIL rsv_busy got=%h want=00000080", busy); end
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h12;
      step();
      b_valid = 1'b0;
      total++;
      if (write_en !== 1'b0) begin bad++; $display("FAIL b_latency1 got=%b want=0", write_en); end
      step();
      total++;
      if (write_en !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'h12 || busy !== 32'h0) begin
         bad++; $display("FAIL b_write got=%b/%0d/%h busy=%h want=1/7/12 busy=0",
                         write_en, write_addr, write_data, busy);
      end
   endtask

   task automatic test_starve();
      logic [31:0] exp_busy;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      int          n;
      n = 0;
      for (int k = 0; k < 4; k++) reserve(5'(20 + k));
      total++;
      if (busy !== 32'h00F0_0000) begin bad++; $display("FAIL starve_rsv got=%h want=00f00000", busy); end
      // FIFO empty in this first cycle, so A winning is not a loss.
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA000_0000;
      b_valid = 1'b1; b_addr = 5'd20; b_data = 32'hB000_0000;
      step();
      n = 1;
      total++;
      if (write_en !== 1'b1 || write_addr !== 5'd1) begin
         bad++; $display("FAIL starve_first got=%b/%0d want=1/1", write_en, write_addr);
      end
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) begin
            a_valid = 1'b1;
            a_addr  = 5'(1 + n % 15);
            a_data  = 32'hA000_0000 + 32'(n);
            exp_addr = a_addr;
            exp_data = a_data;
            if (r == 0 && i < 3) begin
               b_valid = 1'b1; b_addr = 5'(21 + i); b_data = 32'hB000_0001 + 32'(i);
            end else begin
               b_valid = 1'b0;
            end
            step();
            n++;
            total++;
            if (write_en !== 1'b1 || write_addr !== exp_addr || write_data !== exp_data) begin
               bad++; $display("FAIL starve_a_win r=%0d i=%0d got=%b/%0d/%h want=1/%0d/%h",
                               r, i, write_en, write_addr, write_data, exp_addr, exp_data);
            end
            total++;
            if (a_stall !== (i == 7)) begin
               bad++; $display("FAIL starve_stall r=%0d i=%0d got=%b want=%b", r, i, a_stall, i == 7);
            end
            if (r == 0 && i == 2) begin
               total++;
               if (b_ready !== 1'b0) begin bad++; $display("FAIL starve_full got=%b want=0", b_ready); end
            end
         end
         a_valid = 1'b0;
         b_valid = 1'b0;
         step();
         exp_busy = 32'h00F0_0000 & ~((32'h1 << (21 + r)) - 32'h1);
         total++;
         if (write_en !== 1'b1 || write_addr !== 5'(20 + r) || write_data !== 32'hB000_0000 + 32'(r)) begin
            bad++; $display("FAIL starve_drain r=%0d got=%b/%0d/%h want=1/%0d/%h", r, write_en,
                            write_addr, write_data, 20 + r, 32'hB000_0000 + 32'(r));
         end
         total++;
         if (a_stall !== 1'b0 || b_ready !== 1'b1 || busy !== exp_busy) begin
            bad++; $display("FAIL starve_after r=%0d got stall=%b ready=%b busy=%h want 0/1/%h",
                            r, a_stall, b_ready, busy, exp_busy);
         end
      end
   endtask

   task automatic test_addr0();
      reserve(5'd12);
      b_valid = 1'b1; b_addr = 5'd12; b_data = 32'h55;
      step();
      b_valid = 1'b0;
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
      step();
      a_valid = 1'b0;
      total++;
      if (write_en !== 1'b1 || write_addr !== 5'd12 || write_data !== 32'h55 || busy !== 32'h0) begin
         bad++; $display("FAIL addr0_a_slot got=%b/%0d/%h busy=%h want=1/12/55 busy=0",
                         write_en, write_addr, write_data, busy);
      end
      for (int i = 0; i < 4; i++) begin
         a_valid = 1'b1; a_addr = 5'(1 + i); a_data = 32'hC0 + 32'(i);
         b_valid = 1'b1;
         b_addr  = (i == 0) ? 5'd0 : 5'(12 + i);
         b_data  = (i == 0) ? 32'h99 : 32'(12 + i);
         step();
         total++;
         if (write_en !== 1'b1 || write_addr !== 5'(1 + i)) begin
            bad++; $display("FAIL addr0_fill i=%0d got=%b/%0d want=1/%0d", i, write_en, write_addr, 1 + i);
         end
      end
      a_valid = 1'b0; b_valid = 1'b0;
      total++;
      if (b_ready !== 1'b0) begin bad++; $display("FAIL addr0_full got=%b want=0", b_ready); end
      step();
      total++;
      if (write_en !== 1'b0 || b_ready !== 1'b1) begin
         bad++; $display("FAIL addr0_silent_pop got we=%b ready=%b want 0/1", write_en, b_ready);
      end
      for (int i = 1; i < 4; i++) begin
         step();
         total++;
         if (write_en !== 1'b1 || write_addr !== 5'(12 + i) || write_data !== 32'(12 + i)) begin
            bad++; $display("FAIL addr0_drain i=%0d got=%b/%0d/%h want=1/%0d/%h", i, write_en,
                            write_addr, write_data, 12 + i, 12 + i);
         end
      end
      step();
      total++;
      if (write_en !== 1'b0) begin bad++; $display("FAIL addr0_idle got=%b want=0", write_en); end
   endtask

   task automatic test_same_cycle();
      reserve(5'd9);
      b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h77;
      step();
      b_valid = 1'b0;
      rsv_en = 1'b1; rsv_addr = 5'd9;
      step();
      rsv_en = 1'b0;
      total++;
      if (write_en !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'h77) begin
         bad++; $display("FAIL same_write got=%b/%0d/%h want=1/9/77", write_en, write_addr, write_data);
      end
      total++;
      if (busy !== 32'h0000_0200) begin bad++; $display("FAIL same_busy got=%h want=00000200", busy); end
   endtask

   task automatic test_reset_mid();
      reserve(5'd8);
      reserve(5'd10);
      reserve(5'd11);
      total++;
      if (busy !== 32'h0000_0F00) begin bad++; $display("FAIL rst_busy_pre got=%h want=00000f00", busy); end
      for (int i = 0; i < 4; i++) begin
         a_valid = 1'b1; a_addr = 5'(1 + i); a_data = 32'hD0 + 32'(i);
         b_valid = 1'b1; b_addr = 5'(16 + i); b_data = 32'hE0 + 32'(i);
         step();
      end
      b_valid = 1'b0;
      total++;
      if (b_ready !== 1'b0 || write_en !== 1'b1) begin
         bad++; $display("FAIL rst_pre got ready=%b we=%b want 0/1", b_ready, write_en);
      end
      #3 rst = 1'b1;
      a_valid = 1'b0;
      #1;
      total++;
      if ({write_en, write_addr, write_data} !== 38'd0 || b_ready !== 1'b1) begin
         bad++; $display("FAIL rst_async_write got=%b/%0d/%h ready=%b want=0/0/0 ready=1",
                         write_en, write_addr, write_data, b_ready);
      end
      total++;
      if (busy !== 32'h0 || a_stall !== 1'b0) begin
         bad++; $display("FAIL rst_async_state got busy=%h stall=%b want 0/0", busy, a_stall);
      end
      @(posedge clk);
      #3 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         total++;
         if (write_en !== 1'b0) begin bad++; $display("FAIL rst_no_write i=%0d got=%b want=0", i, write_en); end
      end
   endtask

   initial begin
      test_reset();
      test_a_basic();
      test_b_basic();
      test_starve();
      test_addr0();
      test_same_cycle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
